// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control path.
// Holds the ALU control codes, the R-type funct encodings, the ALUOp classes
// and the sequencer FSM state type. Imported by alu_op_decode, the sequencer
// and its interface users.
package alu_ctrl_pkg;

  // ALU control codes driven on alu_ctrl
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_AND  = 2;
  localparam int unsigned ALU_OR   = 3;
  localparam int unsigned ALU_XOR  = 4;
  localparam int unsigned ALU_SLL  = 5;
  localparam int unsigned ALU_SRL  = 6;
  localparam int unsigned ALU_BEQ  = 7;
  localparam int unsigned ALU_BNE  = 8;
  localparam int unsigned ALU_BGT  = 9;
  localparam int unsigned ALU_BGE  = 10;
  localparam int unsigned ALU_BLT  = 11;
  localparam int unsigned ALU_BLE  = 12;
  localparam int unsigned ALU_SLT  = 13;
  localparam int unsigned ALU_PASS = 14;  // ALU outputs operand B unchanged

  // R-type funct field encodings
  localparam logic [5:0] ADDFN = 6'b100000;
  localparam logic [5:0] SUBFN = 6'b100010;
  localparam logic [5:0] ANDFN = 6'b100100;
  localparam logic [5:0] ORFN  = 6'b100101;
  localparam logic [5:0] XORFN = 6'b100110;
  localparam logic [5:0] SLLFN = 6'b000000;
  localparam logic [5:0] SRLFN = 6'b000010;

  // ALUOp classes from the main control FSM
  localparam int unsigned ALUOP_RTYPE = 0;
  localparam int unsigned ALUOP_ADD   = 1;
  localparam int unsigned ALUOP_AND   = 2;
  localparam int unsigned ALUOP_OR    = 3;
  localparam int unsigned ALUOP_BEQ   = 4;
  localparam int unsigned ALUOP_BNE   = 5;
  localparam int unsigned ALUOP_BGT   = 6;
  localparam int unsigned ALUOP_BGE   = 7;
  localparam int unsigned ALUOP_BLT   = 8;
  localparam int unsigned ALUOP_BLE   = 9;
  localparam int unsigned ALUOP_SLT   = 10;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StShift
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/ALU-control bundle between the main control FSM, the ALU op
// sequencer and the datapath ALU.
//   master: main control side, drives the request and flush, observes results
//   slave : sequencer side, accepts requests, drives the ALU control outputs
interface alu_op_sequencer_if #(
  parameter int unsigned OP_W    = 4,
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned SHAMT_W = 5
);
  // request side
  logic               op_valid;
  logic               op_ready;
  logic [OP_W-1:0]    alu_op;
  logic [5:0]         funct;
  logic [SHAMT_W-1:0] shamt;
  logic               flush;
  // ALU control side
  logic [CTRL_W-1:0]  alu_ctrl;
  logic               alu_en;
  logic               alu_first;
  logic [SHAMT_W-1:0] alu_shamt;
  logic               busy;
  logic               done;
  logic               illegal;

  modport master (
    output op_valid, alu_op, funct, shamt, flush,
    input  op_ready, alu_ctrl, alu_en, alu_first, alu_shamt, busy, done, illegal
  );

  modport slave (
    input  op_valid, alu_op, funct, shamt, flush,
    output op_ready, alu_ctrl, alu_en, alu_first, alu_shamt, busy, done, illegal
  );
endinterface

// File: rtl/alu_op_decode.sv
// Combinational ALU control decode, shared with the single-cycle build.
// Ports:
//   alu_op_i   : operation class from main control
//   funct_i    : R-type function field (used only when alu_op_i is R-type)
//   code_o     : ALU control code
//   is_shift_o : R-type SLL/SRL
//   illegal_o  : R-type with an undecoded funct (code falls back to ADD)
module alu_op_decode
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W   = 4,
  parameter int unsigned CTRL_W = 4
) (
  input  logic [OP_W-1:0]   alu_op_i,
  input  logic [5:0]        funct_i,
  output logic [CTRL_W-1:0] code_o,
  output logic              is_shift_o,
  output logic              illegal_o
);

  always_comb begin
    code_o     = CTRL_W'(ALU_ADD);
    is_shift_o = 1'b0;
    illegal_o  = 1'b0;
    if (alu_op_i == OP_W'(ALUOP_RTYPE)) begin
      case (funct_i)
        ADDFN:   code_o = CTRL_W'(ALU_ADD);
        SUBFN:   code_o = CTRL_W'(ALU_SUB);
        ANDFN:   code_o = CTRL_W'(ALU_AND);
        ORFN:    code_o = CTRL_W'(ALU_OR);
        XORFN:   code_o = CTRL_W'(ALU_XOR);
        SLLFN: begin
          code_o     = CTRL_W'(ALU_SLL);
          is_shift_o = 1'b1;
        end
        SRLFN: begin
          code_o     = CTRL_W'(ALU_SRL);
          is_shift_o = 1'b1;
        end
        default: illegal_o = 1'b1;
      endcase
    end else begin
      case (alu_op_i)
        OP_W'(ALUOP_ADD): code_o = CTRL_W'(ALU_ADD);
        OP_W'(ALUOP_AND): code_o = CTRL_W'(ALU_AND);
        OP_W'(ALUOP_OR):  code_o = CTRL_W'(ALU_OR);
        OP_W'(ALUOP_BEQ): code_o = CTRL_W'(ALU_BEQ);
        OP_W'(ALUOP_BNE): code_o = CTRL_W'(ALU_BNE);
        OP_W'(ALUOP_BGT): code_o = CTRL_W'(ALU_BGT);
        OP_W'(ALUOP_BGE): code_o = CTRL_W'(ALU_BGE);
        OP_W'(ALUOP_BLT): code_o = CTRL_W'(ALU_BLT);
        OP_W'(ALUOP_BLE): code_o = CTRL_W'(ALU_BLE);
        OP_W'(ALUOP_SLT): code_o = CTRL_W'(ALU_SLT);
        default:          code_o = CTRL_W'(ALU_ADD);
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered ALU control sequencer for the multicycle datapath.
// Accepts {alu_op, funct, shamt} on a valid/ready handshake and drives a
// registered ALU control code. With ITER_SHIFT = 1, shifts run as shamt
// single-bit steps, one per cycle. done pulses on the final step.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of alu_op_sequencer_if (request in, ALU control out)
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned OP_W       = 4,
  parameter int unsigned CTRL_W     = 4,
  parameter int unsigned SHAMT_W    = 5,
  parameter int unsigned ITER_SHIFT = 1
) (
  input logic              clk,
  input logic              rst_n,
  alu_op_sequencer_if.slave bus
);

  seq_state_e         state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;      // steps remaining, including the one on the outputs
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [SHAMT_W-1:0] shamt_q, shamt_d;
  logic               en_q, en_d;
  logic               first_q, first_d;
  logic               done_q, done_d;
  logic               illegal_q, illegal_d;
  logic               busy_q, busy_d;

  logic [CTRL_W-1:0]  dec_code;
  logic               dec_is_shift;
  logic               dec_illegal;
  logic               iter_shift;

  alu_op_decode #(
    .OP_W   (OP_W),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .alu_op_i   (bus.alu_op),
    .funct_i    (bus.funct),
    .code_o     (dec_code),
    .is_shift_o (dec_is_shift),
    .illegal_o  (dec_illegal)
  );

  assign iter_shift = (ITER_SHIFT != 0) && dec_is_shift;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    shamt_d   = shamt_q;
    en_d      = 1'b0;
    first_d   = 1'b0;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    busy_d    = 1'b0;

    if (bus.flush) begin
      // Abort; a request in the same cycle is dropped
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.op_valid) begin
            busy_d  = 1'b1;
            en_d    = 1'b1;
            first_d = 1'b1;
            if (iter_shift && (bus.shamt != '0)) begin
              state_d = StShift;
              cnt_d   = bus.shamt;
              ctrl_d  = dec_code;
              shamt_d = SHAMT_W'(1);
              done_d  = (bus.shamt == SHAMT_W'(1));
            end else begin
              // Iterative shift by zero degenerates to passing operand B
              state_d   = StExec;
              ctrl_d    = iter_shift ? CTRL_W'(ALU_PASS) : dec_code;
              shamt_d   = bus.shamt;
              done_d    = 1'b1;
              illegal_d = dec_illegal;
            end
          end
        end
        StExec: begin
          state_d = StIdle;
        end
        StShift: begin
          if (cnt_q == SHAMT_W'(1)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d  = cnt_q - SHAMT_W'(1);
            busy_d = 1'b1;
            en_d   = 1'b1;
            done_d = (cnt_q == SHAMT_W'(2));
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      shamt_q   <= '0;
      en_q      <= 1'b0;
      first_q   <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      shamt_q   <= shamt_d;
      en_q      <= en_d;
      first_q   <= first_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.op_ready  = ~busy_q;
  assign bus.alu_ctrl  = ctrl_q;
  assign bus.alu_shamt = shamt_q;
  assign bus.alu_en    = en_q;
  assign bus.alu_first = first_q;
  assign bus.done      = done_q;
  assign bus.illegal   = illegal_q;
  assign bus.busy      = busy_q;

endmodule
